// File: rtl/dm_banked.sv
// rtl/dm_banked.sv - word-addressed data memory with byte strobes, registered read and range error
// Define DM_CLEAR_EN to compile in the post-reset zero-fill sequencer.
module dm_banked #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  sel,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     direccion,
   input  logic [DATA_W/8-1:0]   byte_en,
   input  logic [DATA_W-1:0]     dataWrite,
   output logic                  ready,
   output logic                  rvalid,
   output logic [DATA_W-1:0]     bus_dataRead,
   output logic                  err
);
   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   mem [0:DEPTH-1];
   logic                accept;
   logic                in_range;
   logic [IDX_W-1:0]    idx;

   assign accept   = req & sel & ready;
   assign in_range = {1'b0, direccion} < LIMIT;
   assign idx      = direccion[IDX_W-1:0];

`ifdef DM_CLEAR_EN
   logic [IDX_W-1:0] clr_cnt;
   logic             clr_done;

   assign clr_done = (clr_cnt == IDX_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         clr_cnt <= '0;
      else if (state == INIT)
         clr_cnt <= clr_cnt + IDX_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= INIT;
      else
         state <= state_next;
   end

   // Without the sequencer INIT lasts only until the first edge after release.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         INIT: begin
`ifdef DM_CLEAR_EN
            if (clr_done)
               state_next = RUN;
`else
            state_next = RUN;
`endif
         end
         RUN: ready = 1'b1;
      endcase
   end

   // Array has no reset; the sequencer zero-fills it one word per cycle.
   always_ff @(posedge clk) begin
`ifdef DM_CLEAR_EN
      if (state == INIT)
         mem[clr_cnt] <= '0;
      else
`endif
      if (accept && we && in_range) begin
         for (int k = 0; k < LANES; k++)
            if (byte_en[k])
               mem[idx][8*k +: 8] <= dataWrite[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid       <= 1'b0;
         err          <= 1'b0;
         bus_dataRead <= '0;
      end else begin
         rvalid <= accept & ~we;
         err    <= accept & ~in_range;
         if (accept && !we)
            bus_dataRead <= in_range ? mem[idx] : '0;
      end
   end
endmodule

// File: tb/tb_dm_banked.sv
// tb/tb_dm_banked.sv - self-checking bench for dm_banked (DATA_W=64, ADDR_W=5, DEPTH=16)
// Works with or without DM_CLEAR_EN defined.
module tb_dm_banked;
   logic        clk;
   logic        rst_n;
   logic        req;
   logic        sel;
   logic        we;
   logic [4:0]  direccion;
   logic [7:0]  byte_en;
   logic [63:0] dataWrite;
   logic        ready;
   logic        rvalid;
   logic [63:0] bus_dataRead;
   logic        err;

   int errors = 0;
   int checks = 0;

`ifdef DM_CLEAR_EN
   localparam int READY_AFTER = 16;
`else
   localparam int READY_AFTER = 1;
`endif

   dm_banked #(.DATA_W(64), .ADDR_W(5), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .we(we),
      .direccion(direccion), .byte_en(byte_en), .dataWrite(dataWrite),
      .ready(ready), .rvalid(rvalid), .bus_dataRead(bus_dataRead), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a 16-word array plus the response expected after each edge.
   logic [63:0] mem_m [0:15];
   int          edges_m    = 0;
   logic        exp_ready  = 1'b0;
   logic        exp_rvalid = 1'b0;
   logic        exp_err    = 1'b0;
   logic [63:0] exp_data   = 64'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edges_m    <= 0;
         exp_ready  <= 1'b0;
         exp_rvalid <= 1'b0;
         exp_err    <= 1'b0;
         exp_data   <= 64'h0;
`ifdef DM_CLEAR_EN
         for (int i = 0; i < 16; i++) mem_m[i] <= 64'h0;
`endif
      end else begin
         exp_rvalid <= 1'b0;
         exp_err    <= 1'b0;
         if (edges_m >= READY_AFTER && req && sel) begin
            if (direccion >= 5'd16) begin
               exp_err <= 1'b1;
               if (!we) begin
                  exp_rvalid <= 1'b1;
                  exp_data   <= 64'h0;
               end
            end else if (we) begin
               for (int k = 0; k < 8; k++)
                  if (byte_en[k]) mem_m[direccion[3:0]][8*k +: 8] <= dataWrite[8*k +: 8];
            end else begin
               exp_rvalid <= 1'b1;
               exp_data   <= mem_m[direccion[3:0]];
            end
         end
         edges_m   <= edges_m + 1;
         exp_ready <= (edges_m + 1 >= READY_AFTER);
      end
   end

   always @(negedge clk) begin
      chk("ready", 64'(ready), 64'(exp_ready));
      chk("rvalid", 64'(rvalid), 64'(exp_rvalid));
      chk("err", 64'(err), 64'(exp_err));
      chk("bus_dataRead", bus_dataRead, exp_data);
   end

   task automatic cyc(input logic r, input logic s, input logic w, input logic [4:0] a,
                      input logic [7:0] be, input logic [63:0] d);
      @(negedge clk);
      req = r; sel = s; we = w; direccion = a; byte_en = be; dataWrite = d;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 64'h0);
   endtask

   task automatic wait_ready(input string name, input int expect_n);
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(n), 64'(expect_n));
   endtask

   function automatic logic [63:0] pat(input int i);
      return 64'hA5A5_0000_C3C3_0000 + 64'(i) * 64'h0000_0101_0000_0011;
   endfunction

   initial begin
      rst_n = 1'b0;
      req = 1'b0; sel = 1'b0; we = 1'b0; direccion = 5'd0; byte_en = 8'h00; dataWrite = 64'h0;
      repeat (2) @(negedge clk);
      chk("reset_ready", 64'(ready), 64'h0);
      chk("reset_rvalid", 64'(rvalid), 64'h0);
      chk("reset_err", 64'(err), 64'h0);
      chk("reset_data", bus_dataRead, 64'h0);

`ifdef DM_CLEAR_EN
      req = 1'b1; sel = 1'b1; we = 1'b0; direccion = 5'd3;
      rst_n = 1'b1;
      wait_ready("clear_cycles", 16);
      @(negedge clk);
      chk("clear_rd3_rvalid", 64'(rvalid), 64'h1);
      chk("clear_rd3_data", bus_dataRead, 64'h0);
      idle();
`else
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_first_edge", 64'(ready), 64'h1);
`endif

      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, 5'(i), 8'hFF, pat(i));

      cyc(1'b1, 1'b1, 1'b1, 5'd5, 8'hFF, 64'h1122334455667788);
      cyc(1'b1, 1'b1, 1'b1, 5'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
      cyc(1'b1, 1'b1, 1'b0, 5'd5, 8'h00, 64'h0);
      idle();
      chk("byte_lanes", bus_dataRead, 64'h11223344AAAAAAAA);

      cyc(1'b1, 1'b1, 1'b1, 5'd6, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc(1'b1, 1'b1, 1'b0, 5'd6, 8'h00, 64'h0);
      idle();
      chk("byte_en_zero_noop", bus_dataRead, pat(6));

      cyc(1'b1, 1'b1, 1'b1, 5'd2, 8'hFF, 64'hDEAD);
      cyc(1'b1, 1'b1, 1'b0, 5'd2, 8'h00, 64'h0);
      idle();
      chk("raw_rvalid", 64'(rvalid), 64'h1);
      chk("raw_data", bus_dataRead, 64'hDEAD);

      cyc(1'b1, 1'b1, 1'b0, 5'd20, 8'h00, 64'h0);
      idle();
      chk("oor_rd_rvalid", 64'(rvalid), 64'h1);
      chk("oor_rd_err", 64'(err), 64'h1);
      chk("oor_rd_data", bus_dataRead, 64'h0);
      cyc(1'b1, 1'b1, 1'b1, 5'd20, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
      idle();
      chk("oor_wr_err", 64'(err), 64'h1);
      chk("oor_wr_rvalid", 64'(rvalid), 64'h0);
      cyc(1'b1, 1'b1, 1'b0, 5'd4, 8'h00, 64'h0);
      idle();
      chk("oor_wr_addr4_kept", bus_dataRead, pat(4));

      cyc(1'b1, 1'b0, 1'b1, 5'd7, 8'hFF, 64'h55);
      cyc(1'b1, 1'b1, 1'b0, 5'd7, 8'h00, 64'h0);
      idle();
      chk("sel_gated", bus_dataRead, pat(7));

      for (int i = 15; i >= 0; i--) cyc(1'b1, 1'b1, 1'b0, 5'(i), 8'h00, 64'h0);
      idle();
      chk("b2b_last_data", bus_dataRead, pat(0));

      cyc(1'b1, 1'b1, 1'b0, 5'd9, 8'h00, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_kill_rvalid", 64'(rvalid), 64'h0);
      chk("rst_kill_data", bus_dataRead, 64'h0);
      req = 1'b0; sel = 1'b0;

`ifdef DM_CLEAR_EN
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_ready("reclear_cycles", 16);
      cyc(1'b1, 1'b1, 1'b0, 5'd9, 8'h00, 64'h0);
      idle();
      chk("reclear_rd9", bus_dataRead, 64'h0);
`else
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1'b1, 1'b1, 1'b0, 5'd9, 8'h00, 64'h0);
      idle();
      chk("preserved_rd9", bus_dataRead, pat(9));
`endif

      repeat (3) idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
